alu_v2: RTL and testbench

Parametrised successor to the single-cycle integer ALU. It wraps a registered ALU datapath behind a valid/ready handshake and adds RV32M-style unsigned multiply, divide and remainder. Divide and remainder run on an iterative restoring divider, one quotient bit per cycle. The block sits in the execute stage and stalls upstream through in_ready while a divide is in flight.

---
 rtl/alu_v2.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_v2.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_v2.sv
// Registered integer ALU behind a valid/ready handshake, with unsigned multiply
// and an iterative restoring divider that produces one quotient bit per cycle.
module alu_v2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic [7:0]       error_vector,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_CONST = 4'd15;

  localparam logic [7:0] ERR_OK    = 8'h00;
  localparam logic [7:0] ERR_DIV0  = 8'h01;
  localparam logic [7:0] ERR_UNDEF = 8'hFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       err_q, err_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             rem_op_q, rem_op_d;
  logic [SHW:0]     cnt_q, cnt_d;

  logic             accept_s;
  logic             consume_s;
  logic             div_start_s;
  logic [SHW-1:0]   shamt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [7:0]       alu_err_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_step_s;
  logic             qbit_s;

  assign in_ready     = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept_s     = in_valid && in_ready;
  assign consume_s    = valid_q && out_ready;
  assign div_start_s  = accept_s && ((op_code == OP_DIVU) || (op_code == OP_REMU)) && (b != ZERO_W);
  assign shamt_s      = b[SHW-1:0];
  assign prod_s       = {ZERO_W, a} * {ZERO_W, b};

  assign out          = out_q;
  assign error_vector = err_q;
  assign zero_flag    = zero_q;
  assign sign_flag    = sign_q;
  assign out_valid    = valid_q;
  assign busy         = busy_q;

  // Single-cycle datapath; divide ops here only cover the divide-by-zero case.
  always_comb begin
    alu_res_s = ZERO_W;
    alu_err_s = ERR_OK;
    case (op_code)
      OP_ADD:   alu_res_s = a + b;
      OP_SUB:   alu_res_s = a - b;
      OP_AND:   alu_res_s = a & b;
      OP_OR:    alu_res_s = a | b;
      OP_XOR:   alu_res_s = a ^ b;
      OP_SLL:   alu_res_s = a << shamt_s;
      OP_SRL:   alu_res_s = a >> shamt_s;
      OP_SRA:   alu_res_s = $signed(a) >>> shamt_s;
      OP_SLT:   alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:   alu_res_s = prod_s[WIDTH-1:0];
      OP_MULHU: alu_res_s = prod_s[2*WIDTH-1:WIDTH];
      OP_DIVU: begin
        alu_res_s = ONES_W;
        alu_err_s = ERR_DIV0;
      end
      OP_REMU: begin
        alu_res_s = a;
        alu_err_s = ERR_DIV0;
      end
      OP_CONST: alu_res_s = {(WIDTH/8){8'hF7}};
      default: begin
        alu_res_s = ZERO_W;
        alu_err_s = ERR_UNDEF;
      end
    endcase
  end

  // One restoring-division step: shift {rem,quo} left, trial-subtract divisor.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_q};
    if (!diff_s[WIDTH]) begin
      rem_step_s = diff_s[WIDTH-1:0];
      qbit_s     = 1'b1;
    end else begin
      rem_step_s = rem_sh_s[WIDTH-1:0];
      qbit_s     = 1'b0;
    end
  end

  // Next-state and result-register control.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    err_d    = err_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_op_d = rem_op_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (div_start_s) begin
          rem_d    = ZERO_W;
          quo_d    = a;
          dvs_d    = b;
          rem_op_d = (op_code == OP_REMU);
          cnt_d    = CNT_INIT;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          state_d  = S_DIV;
        end else if (accept_s) begin
          out_d   = alu_res_s;
          err_d   = alu_err_s;
          valid_d = 1'b1;
        end else if (consume_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      S_DIV: begin
        if (cnt_q != {(SHW+1){1'b0}}) begin
          rem_d = rem_step_s;
          quo_d = {quo_q[WIDTH-2:0], qbit_s};
          cnt_d = cnt_q - {{SHW{1'b0}}, 1'b1};
          if (consume_s) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else begin
          out_d   = rem_op_q ? rem_q : quo_q;
          err_d   = ERR_OK;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    zero_d = (out_d == ZERO_W);
    sign_d = out_d[WIDTH-1];
  end

  // State and result registers; reset abandons any divide in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_q    <= ZERO_W;
      err_q    <= ERR_OK;
      zero_q   <= 1'b1;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      rem_q    <= ZERO_W;
      quo_q    <= ZERO_W;
      dvs_q    <= ZERO_W;
      rem_op_q <= 1'b0;
      cnt_q    <= {(SHW+1){1'b0}};
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_op_q <= rem_op_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_v2.sv
// Directed bench for alu_v2: a 32-bit instance for the full op set, handshake and
// divider, plus an 8-bit instance for the width-dependent cases.
module tb_alu_v2;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, zero_flag, sign_flag, busy;
  logic [31:0] a, b, out;
  logic [3:0]  op_code;
  logic [7:0]  error_vector;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, sign8, busy8;
  logic [7:0]  a8, b8, out8, err8;
  logic [3:0]  op8;

  int checks = 0;
  int errors = 0;
  int lat;
  bit bad;
  logic [31:0] held_out;
  logic [7:0]  held_err;
  logic        held_z, held_s;

  alu_v2 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_code(op_code), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero_flag(zero_flag), .sign_flag(sign_flag),
    .error_vector(error_vector), .busy(busy)
  );

  alu_v2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op_code(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out(out8), .zero_flag(zero8), .sign_flag(sign8),
    .error_vector(err8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    op_code  = op;
    a        = x;
    b        = y;
    tick();
    in_valid = 1'b0;
  endtask

  // Accepts a divide, keeps a stray request on in_valid for a while, and measures latency.
  task automatic div_run(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    issue(op, x, y);
    in_valid = 1'b1;
    op_code  = 4'd0;
    a        = 32'd1;
    b        = 32'd1;
    lat      = 0;
    bad      = 1'b0;
    while (!out_valid && lat < 100) begin
      if (!(busy === 1'b1 && in_ready === 1'b0)) bad = 1'b1;
      if (lat == 20) in_valid = 1'b0;
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0; op_code = 4'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = 8'd0; b8 = 8'd0; op8 = 4'd0;
    tick();
    tick();
    chk("rst_out", out, 32'h0);
    chk("rst_flags", {30'd0, zero_flag, sign_flag}, 32'h2);
    chk("rst_err", {24'd0, error_vector}, 32'h0);
    chk("rst_valid_busy_ready", {29'd0, out_valid, busy, in_ready}, 32'h1);
    rst = 1'b0;
    tick();

    chk("add_in_ready", {31'd0, in_ready}, 32'h1);
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap_out", out, 32'h0);
    chk("add_wrap_valid_zero", {30'd0, out_valid, zero_flag}, 32'h3);
    issue(4'd1, 32'd5, 32'd7);
    chk("sub_out", out, 32'hFFFF_FFFE);
    chk("sub_sign", {31'd0, sign_flag}, 32'h1);
    issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and_out", out, 32'hF000_F000);
    issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("or_out", out, 32'hFFF0_FFF0);
    issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor_out", out, 32'h0FF0_0FF0);
    issue(4'd5, 32'h1, 32'd31);
    chk("sll_out", out, 32'h8000_0000);
    issue(4'd6, 32'h80, 32'h23);
    chk("srl_shamt_low_bits", out, 32'h10);
    issue(4'd7, 32'h8000_0000, 32'd4);
    chk("sra_out", out, 32'hF800_0000);
    chk("sra_sign", {31'd0, sign_flag}, 32'h1);
    issue(4'd8, 32'hFFFF_FFFF, 32'h1);
    chk("slt_out", out, 32'h1);
    issue(4'd9, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_out", out, 32'h0);
    issue(4'd10, 32'h0001_0000, 32'h0001_0000);
    chk("mul_out", out, 32'h0);
    issue(4'd11, 32'h0001_0000, 32'h0001_0000);
    chk("mulhu_out", out, 32'h1);
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhu_max", out, 32'hFFFF_FFFE);
    issue(4'd14, 32'h1234_5678, 32'h9);
    chk("undef_out", out, 32'h0);
    chk("undef_err", {24'd0, error_vector}, 32'hFF);
    chk("undef_valid_zero", {30'd0, out_valid, zero_flag}, 32'h3);
    issue(4'd15, 32'h0, 32'h0);
    chk("const_out", out, 32'hF7F7_F7F7);
    chk("const_err", {24'd0, error_vector}, 32'h0);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'h0);

    div_run(4'd12, 32'd100, 32'd7);
    chk("divu_latency", lat, 32'd33);
    chk("divu_busy_stall", {31'd0, bad}, 32'h0);
    chk("divu_out", out, 32'd14);
    chk("divu_done_busy_err", {24'd0, busy, error_vector[6:0]}, 32'h0);
    tick();
    div_run(4'd13, 32'd100, 32'd7);
    chk("remu_latency", lat, 32'd33);
    chk("remu_out", out, 32'd2);
    tick();
    issue(4'd12, 32'd5, 32'd0);
    chk("divu0_valid_busy", {30'd0, out_valid, busy}, 32'h2);
    chk("divu0_out", out, 32'hFFFF_FFFF);
    chk("divu0_err", {24'd0, error_vector}, 32'h01);
    issue(4'd13, 32'd5, 32'd0);
    chk("remu0_out", out, 32'd5);
    chk("remu0_err", {24'd0, error_vector}, 32'h01);
    tick();

    out_ready = 1'b0;
    issue(4'd1, 32'd5, 32'd7);
    held_out = out; held_err = error_vector; held_z = zero_flag; held_s = sign_flag;
    chk("bp_first_result", held_out, 32'hFFFF_FFFE);
    in_valid = 1'b1; op_code = 4'd0; a = 32'd2; b = 32'd3;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
      if (out !== held_out || error_vector !== held_err) bad = 1'b1;
      if (zero_flag !== held_z || sign_flag !== held_s) bad = 1'b1;
      tick();
    end
    chk("bp_stable_10", {31'd0, bad}, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_swap_out", out, 32'd5);
    chk("bp_swap_valid", {31'd0, out_valid}, 32'h1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'h0);

    issue(4'd12, 32'd100, 32'd7);
    repeat (4) tick();
    chk("mid_busy_before_rst", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_busy_ready", {29'd0, out_valid, busy, in_ready}, 32'h1);
    chk("mid_rst_out", out, 32'h0);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("mid_rst_no_result", {31'd0, bad}, 32'h0);

    in_valid8 = 1'b1; op8 = 4'd15; a8 = 8'd0; b8 = 8'd0;
    tick();
    in_valid8 = 1'b0;
    chk("w8_const", {24'd0, out8}, 32'hF7);
    chk("w8_const_sign", {31'd0, sign8}, 32'h1);
    in_valid8 = 1'b1; op8 = 4'd12; a8 = 8'd200; b8 = 8'd3;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      tick();
      lat++;
    end
    chk("w8_divu_latency", lat, 32'd9);
    chk("w8_divu_out", {24'd0, out8}, 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
